// File: rtl/sme_pkg.sv
// sme_stream_driver shared types and constants.
// States, record kinds and SME interface widths.
package sme_pkg;

  localparam int SME_IDX_W   = 5;
  localparam int SME_CHAR_W  = 8;
  localparam int SME_MAX_LEN = 32;

  localparam logic KIND_STRING  = 1'b0;
  localparam logic KIND_PATTERN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_SEND,
    ST_WAIT,
    ST_RESULT
  } sme_state_e;

endpackage

// File: rtl/sme_rec_buf.sv
// Single-record character buffer for the SME transmitter.
// Saturating write pointer, read pointer and registered read port.
module sme_rec_buf
  import sme_pkg::*;
#(
  parameter int MAX_LEN = SME_MAX_LEN,
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int LW = $clog2(MAX_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_first,
  input  logic [SME_CHAR_W-1:0] wr_data,
  input  logic                  rd_start,
  input  logic                  rd_adv,
  output logic [SME_CHAR_W-1:0] rd_data,
  output logic                  rd_last,
  output logic                  drop
);

  logic [SME_CHAR_W-1:0] mem_q [MAX_LEN];
  logic [SME_CHAR_W-1:0] mem_d [MAX_LEN];
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         rd_q, rd_d;
  logic [LW-1:0]         rd_nxt;
  logic [SME_CHAR_W-1:0] dat_q, dat_d;

  // Write path, overflow drop and read-pointer stepping.
  always_comb begin
    mem_d  = mem_q;
    len_d  = len_q;
    rd_d   = rd_q;
    dat_d  = '0;
    drop   = 1'b0;
    rd_nxt = rd_q + LW'(1);
    if (wr_en) begin
      if (wr_first) begin
        mem_d[0] = wr_data;
        len_d    = LW'(1);
      end else if (len_q < LW'(MAX_LEN)) begin
        mem_d[len_q[AW-1:0]] = wr_data;
        len_d = len_q + LW'(1);
      end else begin
        drop = 1'b1;
      end
    end
    if (rd_start) begin
      rd_d  = '0;
      dat_d = mem_q[0];
    end else if (rd_adv) begin
      rd_d  = rd_nxt;
      dat_d = mem_q[rd_nxt[AW-1:0]];
    end
  end

  // Storage array carries no reset; len_q alone marks contents valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      rd_q  <= '0;
      dat_q <= '0;
    end else begin
      len_q <= len_d;
      rd_q  <= rd_d;
      dat_q <= dat_d;
    end
  end

  assign rd_data = dat_q;
  assign rd_last = (rd_q == len_q - LW'(1));

endmodule

// File: rtl/sme_stream_driver.sv
// Host-to-SME record transmitter with result return.
// Buffers one record, replays it framed, waits for SME's verdict.
module sme_stream_driver
  import sme_pkg::*;
#(
  parameter int MAX_LEN = SME_MAX_LEN,
  parameter int TIMEOUT = 1024,
  localparam int TW = $clog2(TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SME_CHAR_W-1:0] in_char,
  input  logic                  in_kind,
  input  logic                  in_last,
  output logic [SME_CHAR_W-1:0] sme_chardata,
  output logic                  sme_isstring,
  output logic                  sme_ispattern,
  input  logic                  sme_valid,
  input  logic                  sme_match,
  input  logic [SME_IDX_W-1:0]  sme_match_index,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_match,
  output logic [SME_IDX_W-1:0]  res_index,
  output logic                  res_timeout,
  output logic                  ovf_sticky
);

  sme_state_e           state_q, state_d;
  logic                 kind_q, kind_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 in_ready_q, in_ready_d;
  logic                 isstr_q, isstr_d;
  logic                 ispat_q, ispat_d;
  logic                 rv_q, rv_d;
  logic                 rm_q, rm_d;
  logic [SME_IDX_W-1:0] ri_q, ri_d;
  logic                 rt_q, rt_d;
  logic                 ovf_q, ovf_d;

  logic                 in_hs, res_hs;
  logic                 wr_en, wr_first;
  logic                 rd_start, rd_adv;
  logic                 rd_last, buf_drop;

  assign in_hs  = in_valid & in_ready_q;
  assign res_hs = rv_q & res_ready;

  sme_rec_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_first (wr_first),
    .wr_data  (in_char),
    .rd_start (rd_start),
    .rd_adv   (rd_adv),
    .rd_data  (sme_chardata),
    .rd_last  (rd_last),
    .drop     (buf_drop)
  );

  // Next state, buffer control, timeout and result capture.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    tmo_d    = tmo_q;
    rm_d     = rm_q;
    ri_d     = ri_q;
    rt_d     = rt_q;
    wr_en    = 1'b0;
    wr_first = 1'b0;
    rd_start = 1'b0;
    rd_adv   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          kind_d   = in_kind;
          wr_en    = 1'b1;
          wr_first = 1'b1;
          state_d  = in_last ? ST_GAP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          wr_en = 1'b1;
          if (in_last) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        rd_start = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (rd_last) begin
          tmo_d   = TW'(1);
          state_d = (kind_q == KIND_PATTERN) ? ST_WAIT : ST_IDLE;
        end else begin
          rd_adv = 1'b1;
        end
      end
      ST_WAIT: begin
        if (sme_valid) begin
          rm_d    = sme_match;
          ri_d    = sme_match ? sme_match_index : '0;
          rt_d    = 1'b0;
          state_d = ST_RESULT;
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          rm_d    = 1'b0;
          ri_d    = '0;
          rt_d    = 1'b1;
          state_d = ST_RESULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESULT: begin
        if (res_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs track the state being entered.
  always_comb begin
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    isstr_d    = (state_d == ST_SEND) && (kind_d == KIND_STRING);
    ispat_d    = (state_d == ST_SEND) && (kind_d == KIND_PATTERN);
    rv_d       = (state_d == ST_RESULT);
    ovf_d      = ovf_q | buf_drop;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_STRING;
      tmo_q      <= '0;
      in_ready_q <= 1'b0;
      isstr_q    <= 1'b0;
      ispat_q    <= 1'b0;
      rv_q       <= 1'b0;
      rm_q       <= 1'b0;
      ri_q       <= '0;
      rt_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      tmo_q      <= tmo_d;
      in_ready_q <= in_ready_d;
      isstr_q    <= isstr_d;
      ispat_q    <= ispat_d;
      rv_q       <= rv_d;
      rm_q       <= rm_d;
      ri_q       <= ri_d;
      rt_q       <= rt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign sme_isstring  = isstr_q;
  assign sme_ispattern = ispat_q;
  assign res_valid     = rv_q;
  assign res_match     = rm_q;
  assign res_index     = ri_q;
  assign res_timeout   = rt_q;
  assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_sme_stream_driver.sv
// Self-checking bench for sme_stream_driver.
// Expected framed characters are queued at acceptance, popped when seen.
module tb_sme_stream_driver;
  import sme_pkg::*;

  localparam int MAXL = 32;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic       in_kind = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] sme_chardata;
  logic       sme_isstring;
  logic       sme_ispattern;
  logic       sme_valid = 1'b0;
  logic       sme_match = 1'b0;
  logic [4:0] sme_match_index = 5'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;
  logic       ovf_sticky;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int frames = 0;
  int first_f = 0;
  int last_f = 0;
  bit rv_seen = 1'b0;
  logic [8:0] exp_q [$];
  logic [7:0] tbuf [64];

  always #5 clk = ~clk;

  sme_stream_driver #(
    .MAX_LEN (MAXL),
    .TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_char         (in_char),
    .in_kind         (in_kind),
    .in_last         (in_last),
    .sme_chardata    (sme_chardata),
    .sme_isstring    (sme_isstring),
    .sme_ispattern   (sme_ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_match       (res_match),
    .res_index       (res_index),
    .res_timeout     (res_timeout),
    .ovf_sticky      (ovf_sticky)
  );

  task automatic cyc();
    logic [8:0] e;
    @(negedge clk);
    cyc_n++;
    if (res_valid) rv_seen = 1'b1;
    if (sme_isstring || sme_ispattern) begin
      if (frames == 0) first_f = cyc_n;
      frames++;
      last_f = cyc_n;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame_extra got s=%b p=%b c=%h want none",
                 sme_isstring, sme_ispattern, sme_chardata);
      end else begin
        e = exp_q.pop_front();
        if ({sme_ispattern, sme_isstring, sme_chardata} !==
            {e[8], ~e[8], e[7:0]}) begin
          bad++;
          $display("FAIL frame_data got p=%b s=%b c=%h want p=%b c=%h",
                   sme_ispattern, sme_isstring, sme_chardata, e[8], e[7:0]);
        end
      end
    end
  endtask

  task automatic clr_frames();
    frames  = 0;
    first_f = 0;
    last_f  = 0;
    rv_seen = 1'b0;
  endtask

  task automatic send_rec(input logic k, input int n);
    int i = 0;
    int g = 0;
    logic acc;
    while (i < n && g < 4 * n + 20) begin
      in_valid = 1'b1;
      in_kind  = k;
      in_char  = tbuf[i];
      in_last  = (i == n - 1);
      acc      = in_ready;
      cyc();
      g++;
      if (acc) begin
        if (i < MAXL) exp_q.push_back({k, tbuf[i]});
        i++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_kind  = 1'b0;
    in_char  = 8'h00;
    total++;
    if (i != n) begin
      bad++;
      $display("FAIL accept_count got=%0d want=%0d", i, n);
    end
  endtask

  task automatic wait_frames(output int got, output int span);
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      cyc();
      g++;
    end
    cyc();
    cyc();
    got  = frames;
    span = (frames == 0) ? 0 : last_f - first_f + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    total++;
    if ({in_ready, sme_chardata, sme_isstring, sme_ispattern, res_valid,
         res_match, res_index, res_timeout, ovf_sticky} !== 20'd0) begin
      bad++;
      $display("FAIL reset_vals got rdy=%b c=%h s=%b p=%b rv=%b want zeros",
               in_ready, sme_chardata, sme_isstring, sme_ispattern, res_valid);
    end
    reset = 1'b0;
    cyc();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_string();
    int got, span;
    tbuf[0] = 8'h41; tbuf[1] = 8'h42; tbuf[2] = 8'h43; tbuf[3] = 8'h44;
    clr_frames();
    send_rec(KIND_STRING, 4);
    wait_frames(got, span);
    repeat (20) cyc();
    total++;
    if (got != 4 || span != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL string_frames got=%0d span=%0d left=%0d want 4/4/0",
               got, span, exp_q.size());
    end
    total++;
    if (rv_seen !== 1'b0) begin
      bad++;
      $display("FAIL string_no_result got=%b want=0", rv_seen);
    end
  endtask

  task automatic test_pattern_match();
    int got, span;
    tbuf[0] = 8'h42; tbuf[1] = 8'h43;
    clr_frames();
    send_rec(KIND_PATTERN, 2);
    wait_frames(got, span);
    total++;
    if (got != 2 || span != 2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL pat_frames got=%0d span=%0d want 2/2", got, span);
    end
    while (cyc_n < last_f + 3) cyc();
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL pat_early got=%b want=0", res_valid);
    end
    sme_valid = 1'b1;
    sme_match = 1'b1;
    sme_match_index = 5'd1;
    cyc();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_match_index = 5'd0;
    total++;
    if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd1, 1'b0}
        || cyc_n - last_f != 4) begin
      bad++;
      $display("FAIL pat_result got v=%b m=%b i=%0d t=%b dt=%0d want 1 1 1 0 4",
               res_valid, res_match, res_index, res_timeout, cyc_n - last_f);
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL pat_release got v=%b rdy=%b want 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int got, span;
    tbuf[0] = 8'h41; tbuf[1] = 8'h44;
    clr_frames();
    res_ready = 1'b1;
    send_rec(KIND_PATTERN, 2);
    wait_frames(got, span);
    sme_valid = 1'b1;
    sme_match = 1'b0;
    sme_match_index = 5'd7;
    cyc();
    sme_valid = 1'b0;
    sme_match_index = 5'd0;
    total++;
    if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL nomatch_result got v=%b m=%b i=%0d t=%b want 1 0 0 0",
               res_valid, res_match, res_index, res_timeout);
    end
    cyc();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_high_release got v=%b rdy=%b want 0 1",
               res_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    int got, span;
    int g = 0;
    tbuf[0] = 8'h58; tbuf[1] = 8'h59;
    clr_frames();
    send_rec(KIND_PATTERN, 2);
    wait_frames(got, span);
    while (!res_valid && g < 100) begin
      cyc();
      g++;
    end
    total++;
    if (res_valid !== 1'b1 || cyc_n - last_f != TMO) begin
      bad++;
      $display("FAIL tmo_latency got v=%b dt=%0d want 1 %0d",
               res_valid, cyc_n - last_f, TMO);
    end
    total++;
    if ({res_timeout, res_match, res_index} !== {1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL tmo_result got t=%b m=%b i=%0d want 1 0 0",
               res_timeout, res_match, res_index);
    end
  endtask

  task automatic test_res_hold();
    for (int k = 0; k < 10; k++) begin
      sme_valid = k[0];
      sme_match = 1'b1;
      sme_match_index = 5'd3;
      cyc();
      total++;
      if ({res_valid, res_match, res_index, res_timeout, in_ready} !==
          {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL hold_%0d got v=%b m=%b i=%0d t=%b rdy=%b want 1 0 0 1 0",
                 k, res_valid, res_match, res_index, res_timeout, in_ready);
      end
    end
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_match_index = 5'd0;
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got v=%b rdy=%b want 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_len_edges();
    int got, span;
    for (int i = 0; i < MAXL; i++) tbuf[i] = 8'h60 + 8'(i);
    clr_frames();
    send_rec(KIND_STRING, MAXL);
    wait_frames(got, span);
    total++;
    if (got != MAXL || span != MAXL || ovf_sticky !== 1'b0) begin
      bad++;
      $display("FAIL full_len got=%0d span=%0d ovf=%b want %0d %0d 0",
               got, span, ovf_sticky, MAXL, MAXL);
    end
    tbuf[0] = 8'h31;
    clr_frames();
    send_rec(KIND_STRING, 1);
    wait_frames(got, span);
    total++;
    if (got != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL one_char got=%0d want 1", got);
    end
  endtask

  task automatic test_overflow();
    int got, span;
    for (int i = 0; i < 40; i++) tbuf[i] = 8'h20 + 8'(i);
    clr_frames();
    send_rec(KIND_STRING, 40);
    wait_frames(got, span);
    total++;
    if (got != MAXL || span != MAXL || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ovf_frames got=%0d span=%0d want %0d", got, span, MAXL);
    end
    total++;
    if (ovf_sticky !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", ovf_sticky);
    end
  endtask

  task automatic test_reset_mid();
    int got, span;
    int g = 0;
    for (int i = 0; i < 6; i++) tbuf[i] = 8'h61 + 8'(i);
    clr_frames();
    send_rec(KIND_STRING, 6);
    while (frames < 3 && g < 50) begin
      cyc();
      g++;
    end
    reset = 1'b1;
    exp_q.delete();
    cyc();
    total++;
    if ({in_ready, sme_chardata, sme_isstring, sme_ispattern, res_valid,
         res_match, res_index, res_timeout, ovf_sticky} !== 20'd0
        || frames != 3) begin
      bad++;
      $display("FAIL mid_reset got fr=%0d s=%b c=%h ovf=%b rdy=%b want 3 0 0 0 0",
               frames, sme_isstring, sme_chardata, ovf_sticky, in_ready);
    end
    reset = 1'b0;
    cyc();
    tbuf[0] = 8'h5a;
    clr_frames();
    send_rec(KIND_STRING, 1);
    wait_frames(got, span);
    total++;
    if (got != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL after_reset got=%0d want 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_string();
    test_pattern_match();
    test_back_to_back();
    test_timeout();
    test_res_hold();
    test_len_edges();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1);
  end

endmodule
